// File: rtl/ktc32_loader_pkg.sv
// Shared constants and state encodings for the serial program loader.
package ktc32_loader_pkg;

  localparam logic [7:0] LOADER_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERROR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle valid or
// framing-error pulse per frame.
module uart_rx
  import ktc32_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  rx_state_t   state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]  bit_idx, bit_n;
  logic [7:0]  shreg, shreg_n;
  logic        valid_n, ferr_n;
  logic        rx_meta, rx_sync, rx_prev;

  // rx_prev lets the idle state see a genuine high-to-low transition.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RX_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shreg     <= shreg_n;
      rx_valid  <= valid_n;
      frame_err <= ferr_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + CW'(1);
    bit_n   = bit_idx;
    shreg_n = shreg;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (rx_prev && !rx_sync) state_n = RX_START;
      end
      // A start bit that is high again at half-bit time was a glitch.
      RX_START: begin
        if (cnt == HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_sync ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          shreg_n = {rx_sync, shreg[7:1]};
          bit_n   = bit_idx + 3'd1;
          if (bit_idx == 3'd7) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt == FULL) begin
          cnt_n   = '0;
          state_n = RX_IDLE;
          valid_n = rx_sync;
          ferr_n  = !rx_sync;
        end
      end
      default: state_n = RX_IDLE;
    endcase
  end

  assign rx_data = shreg;

endmodule

// File: rtl/uart_loader.sv
// Receives a framed, checksummed program image over UART, writes it to RAM
// and releases the CPU from reset once the image is verified.
module uart_loader
  import ktc32_loader_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int BAUD           = 115_200,
  parameter int ADDR_WIDTH     = 14,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  uart_rx,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_WIDTH;

  loader_state_t   state, state_n;
  logic            rx_valid, frame_err;
  logic [7:0]      rx_data;
  logic [15:0]     len;
  logic [ADDR_WIDTH:0] widx;
  logic [7:0]      csum;
  logic [31:0]     word_buf;
  logic [1:0]      byte_idx;
  logic [TW-1:0]   timer;
  logic            in_load, timed_out, last_word, is_header;
  logic [16:0]     new_len;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk      (clk),
    .reset    (reset),
    .rx       (uart_rx),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .frame_err(frame_err)
  );

  assign in_load   = (state == LEN_HI) || (state == LEN_LO) || (state == DATA) || (state == CSUM);
  assign timed_out = in_load && !rx_valid && (timer == TLAST);
  assign new_len   = {1'b0, len[15:8], rx_data};
  assign last_word = (17'(widx) + 17'd1) == {1'b0, len};
  assign is_header = (rx_data == LOADER_HEADER);

  assign busy  = in_load;
  assign done  = (state == DONE);
  assign error = (state == ERROR);

  // Next-state logic; framing errors and timeouts override any byte decode.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, ERROR: if (rx_valid && is_header) state_n = LEN_HI;
      LEN_HI:      if (rx_valid) state_n = LEN_LO;
      LEN_LO: begin
        if (rx_valid) begin
          if (new_len > MAX_WORDS)  state_n = ERROR;
          else if (new_len == '0)   state_n = CSUM;
          else                      state_n = DATA;
        end
      end
      DATA:    if (rx_valid && byte_idx == 2'd3 && last_word) state_n = CSUM;
      CSUM:    if (rx_valid) state_n = (rx_data == csum) ? DONE : ERROR;
      DONE:    state_n = DONE;
      default: state_n = IDLE;
    endcase
    if (in_load && (frame_err || timed_out)) state_n = ERROR;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      len         <= '0;
      widx        <= '0;
      csum        <= '0;
      word_buf    <= '0;
      byte_idx    <= '0;
      timer       <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_reset_n <= 1'b0;
    end else begin
      state       <= state_n;
      mem_we      <= 1'b0;
      cpu_reset_n <= (state == DONE);
      timer       <= (in_load && !rx_valid) ? timer + TW'(1) : '0;
      if (rx_valid) begin
        case (state)
          IDLE, ERROR: begin
            if (is_header) begin
              widx     <= '0;
              csum     <= '0;
              byte_idx <= '0;
            end
          end
          LEN_HI: len[15:8] <= rx_data;
          LEN_LO: len[7:0]  <= rx_data;
          // The fourth byte completes the word; it is written on the next cycle.
          DATA: begin
            csum <= csum ^ rx_data;
            word_buf[{byte_idx, 3'b000} +: 8] <= rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_we    <= 1'b1;
              mem_addr  <= widx[ADDR_WIDTH-1:0];
              mem_wdata <= {rx_data, word_buf[23:0]};
              widx      <= widx + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_loader.sv
// Self-checking bench for uart_loader: vector table of whole images plus
// hand-written corner sequences, RAM writes checked against a scoreboard.
module tb_uart_loader;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int AW       = 4;
  localparam int TO       = 500;
  localparam int CPB      = CLK_FREQ / BAUD;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          uart_rx = 1'b1;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_reset_n, busy, done, error;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [7:0]  b[12];
    int          n;
    int          nwr;
    logic [31:0] w[2];
    logic        exp_done;
    logic        exp_err;
  } vec_t;

  wr_t        exp_q[$];
  wr_t        exp_w;
  vec_t       vecs[4];
  logic [7:0] good_img[12];
  logic [7:0] good_cs;
  logic       prev_we = 1'b0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  uart_loader #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .error(error)
  );

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // Every write must be one cycle wide and match the next scoreboard entry.
  always @(negedge clk) begin
    if (mem_we) begin
      check_output("mem_we_width", {31'd0, prev_we}, 32'd0);
      if (exp_q.size() == 0) begin
        check_output("unexpected_write", {28'd0, mem_addr}, 32'hFFFF_FFFF);
      end else begin
        exp_w = exp_q.pop_front();
        check_output("write_addr", {28'd0, mem_addr}, {28'd0, exp_w.addr});
        check_output("write_data", mem_wdata, exp_w.data);
      end
    end
    prev_we = mem_we;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic apply_stimulus(input logic [7:0] b, input logic stop_ok);
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(posedge clk);
    uart_rx = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic settle();
    repeat (5) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_good_writes();
    exp_q.push_back('{addr: AW'(0), data: 32'h12345678});
    exp_q.push_back('{addr: AW'(1), data: 32'hDEADBEEF});
  endtask

  task automatic send_good();
    for (int i = 0; i < 12; i++) apply_stimulus(good_img[i], 1'b1);
  endtask

  task automatic check_flags(input string tag, input logic e_done, input logic e_err, input logic e_busy);
    check_output({tag, "_done"}, {31'd0, done}, {31'd0, e_done});
    check_output({tag, "_error"}, {31'd0, error}, {31'd0, e_err});
    check_output({tag, "_cpu_reset_n"}, {31'd0, cpu_reset_n}, {31'd0, e_done});
    check_output({tag, "_busy"}, {31'd0, busy}, {31'd0, e_busy});
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check_output({tag, "_mem_addr"}, {28'd0, mem_addr}, 32'd0);
    check_output({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check_flags(tag, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    good_cs = xor4(32'h12345678) ^ xor4(32'hDEADBEEF);
    good_img = '{8'hA5, 8'h00, 8'h02, 8'h78, 8'h56, 8'h34, 8'h12,
                 8'hEF, 8'hBE, 8'hAD, 8'hDE, good_cs};

    vecs[0].b = good_img;
    vecs[0].n = 12; vecs[0].nwr = 2;
    vecs[0].w = '{32'h12345678, 32'hDEADBEEF};
    vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;

    vecs[1].b = good_img;
    vecs[1].b[11] = 8'h00;
    vecs[1].n = 12; vecs[1].nwr = 2;
    vecs[1].w = '{32'h12345678, 32'hDEADBEEF};
    vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;

    vecs[2].b = '{8'h3C, 8'h00, 8'hA5, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[2].n = 6; vecs[2].nwr = 0;
    vecs[2].w = '{32'd0, 32'd0};
    vecs[2].exp_done = 1'b1; vecs[2].exp_err = 1'b0;

    vecs[3].b = '{8'hA5, 8'h00, 8'h11, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    vecs[3].n = 3; vecs[3].nwr = 0;
    vecs[3].w = '{32'd0, 32'd0};
    vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1;

    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int k = 0; k < vecs[v].nwr; k++)
        exp_q.push_back('{addr: AW'(k), data: vecs[v].w[k]});
      for (int j = 0; j < vecs[v].n; j++) apply_stimulus(vecs[v].b[j], 1'b1);
      settle();
      check_flags($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err, 1'b0);
      check_output($sformatf("vec%0d_pending_writes", v), exp_q.size(), 32'd0);
    end

    // Bad checksum, then the same image again without reset recovers.
    do_reset();
    push_good_writes();
    for (int i = 0; i < 11; i++) apply_stimulus(good_img[i], 1'b1);
    apply_stimulus(good_cs ^ 8'hFF, 1'b1);
    settle();
    check_flags("retry_bad", 1'b0, 1'b1, 1'b0);
    push_good_writes();
    send_good();
    settle();
    check_flags("retry_good", 1'b1, 1'b0, 1'b0);
    apply_stimulus(8'hA5, 1'b1);
    settle();
    check_flags("done_sticky", 1'b1, 1'b0, 1'b0);

    // Short low glitch must not start a frame that would corrupt the next one.
    do_reset();
    @(posedge clk);
    uart_rx = 1'b0;
    repeat (4) @(posedge clk);
    uart_rx = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check_output("glitch_busy", {31'd0, busy}, 32'd0);
    apply_stimulus(8'hA5, 1'b1);
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 1'b1);
    settle();
    check_flags("glitch_then_empty", 1'b1, 1'b0, 1'b0);

    // Silence mid-word trips the timeout.
    do_reset();
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h78, 1'b1);
    apply_stimulus(8'h56, 1'b1);
    settle();
    check_flags("before_timeout", 1'b0, 1'b0, 1'b1);
    repeat (TO + 100) @(posedge clk);
    @(negedge clk);
    check_flags("timeout", 1'b0, 1'b1, 1'b0);

    // Framing error in the middle of a word aborts the load.
    do_reset();
    apply_stimulus(8'hA5, 1'b1);
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'h01, 1'b1);
    apply_stimulus(8'h78, 1'b1);
    apply_stimulus(8'h56, 1'b0);
    settle();
    check_flags("frame_err", 1'b0, 1'b1, 1'b0);

    // Reset asserted mid-DATA clears outputs asynchronously.
    do_reset();
    exp_q.push_back('{addr: AW'(0), data: 32'h12345678});
    for (int i = 0; i < 9; i++) apply_stimulus(good_img[i], 1'b1);
    settle();
    check_output("mid_load_wdata", mem_wdata, 32'h12345678);
    check_output("mid_load_busy", {31'd0, busy}, 32'd1);
    #2 reset = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    push_good_writes();
    send_good();
    settle();
    check_flags("after_reset_reload", 1'b1, 1'b0, 1'b0);
    check_output("final_pending_writes", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
